sap_sequencer: RTL

- Fetch/decode/execute controller for the 16x8 program/data memory of the 8-bit microprocessor.
- Owns PC, MAR, IR, accumulator (A), B register, output register and flags.
- Drives the memory address and consumes the memory's combinational read data, one instruction per fixed six-state ring.
- Instruction byte format: [7:4] opcode, [3:0] operand address.

---
 rtl/sap_pkg.sv | 23 ++
 rtl/sap_alu.sv | 29 ++
 rtl/sap_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared constants, opcodes and FSM state type for the SAP sequencer.
package sap_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 8;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_e;

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit: result, carry (add) or borrow (sub), zero.
module sap_alu
    import sap_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    // One extra bit holds the add carry-out, or the borrow when subtracting.
    always_comb begin
        if (sub) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        zero   = (wide[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/sap_sequencer.sv
// Fetch/decode/execute controller: six-state ring per instruction plus HALT.
module sap_sequencer
    import sap_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              zero,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned OP_W = DATA_W - ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    logic [OP_W-1:0]   opcode;
    logic              is_lda, is_add, is_sub, is_out, is_hlt, is_alu;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry, alu_zero;

    assign opcode = ir_q[DATA_W-1:ADDR_W];
    assign is_lda = (opcode == OP_W'(OP_LDA));
    assign is_add = (opcode == OP_W'(OP_ADD));
    assign is_sub = (opcode == OP_W'(OP_SUB));
    assign is_out = (opcode == OP_W'(OP_OUT));
    assign is_hlt = (opcode == OP_W'(OP_HLT));
    assign is_alu = is_add | is_sub;

    sap_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a     (a_q),
        .b     (b_q),
        .sub   (is_sub),
        .result(alu_result),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    // Next-state and register updates; everything holds unless run is high and not halted.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;

        if (run && state_q != S_HALT) begin
            case (state_q)
                S_T1: begin
                    mar_d   = pc_q;
                    state_d = S_T2;
                end
                S_T2: begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_T3;
                end
                S_T3: begin
                    ir_d    = mem_data;
                    state_d = S_T4;
                end
                S_T4: begin
                    if (is_hlt) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_T5;
                        if (is_lda || is_alu) begin
                            mar_d = ir_q[ADDR_W-1:0];
                        end
                        if (is_out) begin
                            out_d       = a_q;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                S_T5: begin
                    state_d = S_T6;
                    if (is_lda) begin
                        a_d = mem_data;
                    end
                    if (is_alu) begin
                        b_d = mem_data;
                    end
                end
                S_T6: begin
                    state_d = S_T1;
                    if (is_alu) begin
                        a_d     = alu_result;
                        carry_d = alu_carry;
                        zero_d  = alu_zero;
                    end
                end
                default: state_d = S_T1;
            endcase
        end
    end

    // State and architectural registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_T1;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    assign mem_addr  = mar_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign acc       = a_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign halted    = (state_q == S_HALT);
    assign pc        = pc_q;

endmodule
